axibram_write_burst: RTL and testbench

AXIBRAM_WRITE_BURST -- requirements
Module: axibram_write_burst

---
 rtl/axibram_write_burst.sv | 216 +++++++++++++++++++++
 tb/tb_axibram_write_burst.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/axibram_write_burst.sv
// AXI3 write-burst slave that turns AW/W bursts into single-beat BRAM writes.
// The AW, W and B channels are FIFO-buffered and one IDLE/BURST sequencer drives the beats.
module axibram_write_burst_fifo #(
    parameter int WIDTH     = 8,
    parameter int DEPTH_LOG = 2
) (
    input  logic                 aclk,
    input  logic                 aresetn,
    input  logic                 push,
    input  logic [WIDTH-1:0]     din,
    input  logic                 pop,
    output logic [WIDTH-1:0]     dout,
    output logic [DEPTH_LOG:0]   count
);
    localparam int DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL_CNT = DEPTH[DEPTH_LOG:0];

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [DEPTH_LOG-1:0] wr_ptr;
    logic [DEPTH_LOG-1:0] rd_ptr;
    logic                 do_push;
    logic                 do_pop;

    // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count != FULL_CNT) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + DEPTH_LOG'(1);
            if (do_pop)  rd_ptr <= rd_ptr + DEPTH_LOG'(1);
            count <= count + (DEPTH_LOG+1)'(do_push) - (DEPTH_LOG+1)'(do_pop);
        end
    end

    always_ff @(posedge aclk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// state | meaning
// IDLE  | no burst in flight, waiting for AW + W + device ready + B room
// BURST | writing beats of the latched burst until beats_left reaches zero
module axibram_write_burst #(
    parameter int ADDRESS_BITS   = 10,
    parameter int DATA_BYTES     = 4,
    parameter int FIFO_DEPTH_LOG = 2
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [31:0]               awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [11:0]               awid,
    input  logic [3:0]                awlen,
    input  logic [1:0]                awsize,
    input  logic [1:0]                awburst,
    input  logic [8*DATA_BYTES-1:0]   wdata,
    input  logic                      wvalid,
    output logic                      wready,
    input  logic [11:0]               wid,
    input  logic                      wlast,
    input  logic [DATA_BYTES-1:0]     wstb,
    output logic                      bvalid,
    input  logic                      bready,
    output logic [11:0]               bid,
    output logic [1:0]                bresp,
    output logic [ADDRESS_BITS-1:0]   pre_awaddr,
    output logic                      start_burst,
    input  logic                      dev_ready,
    input  logic                      dev_error,
    output logic [ADDRESS_BITS-1:0]   bram_waddr,
    output logic                      bram_wen,
    output logic [DATA_BYTES-1:0]     bram_wstb,
    output logic [8*DATA_BYTES-1:0]  bram_wdata
);
    localparam int L   = $clog2(DATA_BYTES);
    localparam int CW  = FIFO_DEPTH_LOG + 1;
    localparam int DW  = 8 * DATA_BYTES;
    localparam int AWW = ADDRESS_BITS + 4 + 2 + 12;
    localparam int WW  = 1 + DATA_BYTES + DW;
    localparam logic [CW-1:0] DEPTH_CNT  = CW'(1 << FIFO_DEPTH_LOG);
    localparam logic [CW-1:0] ALMOST_CNT = DEPTH_CNT - CW'(1);

    typedef enum logic {IDLE, BURST} state_t;
    state_t state;

    logic [AWW-1:0]          aw_head;
    logic [CW-1:0]           aw_cnt;
    logic [CW-1:0]           aw_cnt_nxt;
    logic [WW-1:0]           w_head;
    logic [CW-1:0]           w_cnt;
    logic [CW-1:0]           w_cnt_nxt;
    logic [13:0]             b_head;
    logic [CW-1:0]           b_cnt;
    logic [1:0]              b_resp_new;
    logic                    aw_push;
    logic                    w_push;
    logic                    b_pop;
    logic                    beat;
    logic                    last_beat;
    logic                    b_room;
    logic                    start;
    logic [ADDRESS_BITS-1:0] head_addr;
    logic [3:0]              head_len;
    logic [1:0]              head_burst;
    logic [11:0]             head_id;
    logic                    head_wlast;
    logic [DATA_BYTES-1:0]   head_wstb;
    logic [DW-1:0]           head_wdata;
    logic [ADDRESS_BITS-1:0] addr_r;
    logic [ADDRESS_BITS-1:0] mask_r;
    logic [ADDRESS_BITS-1:0] next_addr;
    logic [3:0]              beats_left;
    logic [1:0]              burst_r;
    logic [11:0]             id_r;
    logic                    err_r;
    logic                    dev_ready_r;
    logic                    unused_ok;

    assign unused_ok = &{1'b0, awsize, wid, awaddr[31:ADDRESS_BITS+L], awaddr[L-1:0]};

    assign aw_push = awvalid && awready;
    assign w_push  = wvalid && wready;
    assign {head_addr, head_len, head_burst, head_id} = aw_head;
    assign {head_wlast, head_wstb, head_wdata}        = w_head;

    axibram_write_burst_fifo #(.WIDTH(AWW), .DEPTH_LOG(FIFO_DEPTH_LOG)) u_aw_fifo (
        .aclk(aclk), .aresetn(aresetn), .push(aw_push),
        .din({awaddr[ADDRESS_BITS+L-1:L], awlen, awburst, awid}),
        .pop(start), .dout(aw_head), .count(aw_cnt)
    );

    axibram_write_burst_fifo #(.WIDTH(WW), .DEPTH_LOG(FIFO_DEPTH_LOG)) u_w_fifo (
        .aclk(aclk), .aresetn(aresetn), .push(w_push), .din({wlast, wstb, wdata}),
        .pop(beat), .dout(w_head), .count(w_cnt)
    );

    axibram_write_burst_fifo #(.WIDTH(14), .DEPTH_LOG(FIFO_DEPTH_LOG)) u_b_fifo (
        .aclk(aclk), .aresetn(aresetn), .push(last_beat), .din({id_r, b_resp_new}),
        .pop(b_pop), .dout(b_head), .count(b_cnt)
    );

    assign beat      = (state == BURST) && (w_cnt != '0) && dev_ready_r;
    assign last_beat = beat && (beats_left == 4'd0);
    // A start on a last beat must leave room for the response that beat pushes as well.
    assign b_room    = (state == BURST) ? (b_cnt < ALMOST_CNT) : (b_cnt < DEPTH_CNT);
    assign start     = (aw_cnt != '0) && (w_cnt != '0) && dev_ready_r && b_room &&
                       ((state == IDLE) || last_beat);

    assign b_resp_new  = (err_r || !head_wlast) ? 2'b10 : 2'b00;
    assign bvalid      = (b_cnt != '0);
    assign b_pop       = bvalid && bready;
    assign bid         = bvalid ? b_head[13:2] : 12'd0;
    assign bresp       = bvalid ? b_head[1:0] : 2'b00;
    assign pre_awaddr  = head_addr;
    assign start_burst = start;
    assign aw_cnt_nxt  = aw_cnt + CW'(aw_push) - CW'(start);
    assign w_cnt_nxt   = w_cnt + CW'(w_push) - CW'(beat);

    always_comb begin
        next_addr = addr_r + ADDRESS_BITS'(1);
        case (burst_r)
            2'b00:   next_addr = addr_r;
            2'b10:   next_addr = (addr_r & ~mask_r) | ((addr_r + ADDRESS_BITS'(1)) & mask_r);
            default: next_addr = addr_r + ADDRESS_BITS'(1);
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state       <= IDLE;
            addr_r      <= '0;
            mask_r      <= '0;
            beats_left  <= '0;
            burst_r     <= '0;
            id_r        <= '0;
            err_r       <= 1'b0;
            dev_ready_r <= 1'b0;
            awready     <= 1'b0;
            wready      <= 1'b0;
            bram_wen    <= 1'b0;
            bram_waddr  <= '0;
            bram_wstb   <= '0;
            bram_wdata  <= '0;
        end else begin
            dev_ready_r <= dev_ready;
            awready     <= (aw_cnt_nxt < ALMOST_CNT);
            wready      <= (w_cnt_nxt < ALMOST_CNT);
            bram_wen    <= beat && !err_r;
            if (beat) begin
                bram_waddr <= addr_r;
                bram_wstb  <= head_wstb;
                bram_wdata <= head_wdata;
                beats_left <= beats_left - 4'd1;
                addr_r     <= next_addr;
            end
            if (start) begin
                state      <= BURST;
                addr_r     <= head_addr;
                beats_left <= head_len;
                mask_r     <= ADDRESS_BITS'(head_len);
                burst_r    <= head_burst;
                id_r       <= head_id;
                err_r      <= dev_error;
            end else if (last_beat) begin
                state <= IDLE;
            end
        end
    end
endmodule

// File: tb/tb_axibram_write_burst.sv
// Scoreboard bench for axibram_write_burst: expected BRAM writes and B responses are
// queued as bursts are driven and compared as the DUT produces them.
`timescale 1ns/1ps
module tb_axibram_write_burst;
    logic        aclk = 1'b0;
    logic        aresetn;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [11:0] awid;
    logic [3:0]  awlen;
    logic [1:0]  awsize;
    logic [1:0]  awburst;
    logic [31:0] wdata;
    logic        wvalid;
    logic        wready;
    logic [11:0] wid;
    logic        wlast;
    logic [3:0]  wstb;
    logic        bvalid;
    logic        bready;
    logic [11:0] bid;
    logic [1:0]  bresp;
    logic [9:0]  pre_awaddr;
    logic        start_burst;
    logic        dev_ready;
    logic        dev_error;
    logic [9:0]  bram_waddr;
    logic        bram_wen;
    logic [3:0]  bram_wstb;
    logic [31:0] bram_wdata;

    always #5 aclk = ~aclk;

    axibram_write_burst dut (
        .aclk(aclk), .aresetn(aresetn),
        .awaddr(awaddr), .awvalid(awvalid), .awready(awready), .awid(awid),
        .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .wdata(wdata), .wvalid(wvalid), .wready(wready), .wid(wid), .wlast(wlast), .wstb(wstb),
        .bvalid(bvalid), .bready(bready), .bid(bid), .bresp(bresp),
        .pre_awaddr(pre_awaddr), .start_burst(start_burst),
        .dev_ready(dev_ready), .dev_error(dev_error),
        .bram_waddr(bram_waddr), .bram_wen(bram_wen), .bram_wstb(bram_wstb), .bram_wdata(bram_wdata)
    );

    typedef struct packed {
        logic [9:0]  a;
        logic [31:0] d;
        logic [3:0]  s;
    } wr_t;

    wr_t         exp_wr[$];
    logic [13:0] exp_b[$];
    int          wen_log[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          wr_seen = 0;
    int          bursts_sent = 0;
    bit          abort = 1'b0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    always @(negedge aclk) begin
        wr_t         e;
        logic [13:0] eb;
        if (aresetn) begin
            if (bram_wen) begin
                wr_seen++;
                wen_log.push_back(cyc);
                check("wen_expected", 64'(exp_wr.size() > 0), 64'(1));
                if (exp_wr.size() > 0) begin
                    e = exp_wr.pop_front();
                    check("bram_waddr", 64'(bram_waddr), 64'(e.a));
                    check("bram_wdata", 64'(bram_wdata), 64'(e.d));
                    check("bram_wstb", 64'(bram_wstb), 64'(e.s));
                end
            end
            if (bvalid && bready) begin
                check("b_expected", 64'(exp_b.size() > 0), 64'(1));
                if (exp_b.size() > 0) begin
                    eb = exp_b.pop_front();
                    check("bid", 64'(bid), 64'(eb[13:2]));
                    check("bresp", 64'(bresp), 64'(eb[1:0]));
                end
            end
        end
    end

    task automatic send_aw(input logic [31:0] a, input logic [3:0] len, input logic [1:0] bt,
                           input logic [11:0] id);
        int n = 0;
        awaddr = a; awlen = len; awburst = bt; awid = id; awsize = 2'b10; awvalid = 1'b1;
        do begin @(negedge aclk); n++; end while (!awready && n < 300 && !abort);
        if (!abort) begin
            check("aw_handshake", 64'(n < 300), 64'(1));
            @(posedge aclk); #1;
        end
        awvalid = 1'b0;
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input logic l,
                          input logic [11:0] id);
        int n = 0;
        wdata = d; wstb = s; wlast = l; wid = id; wvalid = 1'b1;
        do begin @(negedge aclk); n++; end while (!wready && n < 300 && !abort);
        if (!abort) begin
            check("w_handshake", 64'(n < 300), 64'(1));
            @(posedge aclk); #1;
        end
        wvalid = 1'b0;
    endtask

    // Queues the expected writes and response, then drives AW and the W beats concurrently.
    task automatic burst(input logic [31:0] a, input logic [3:0] len, input logic [1:0] bt,
                         input logic [11:0] id, input bit err, input logic [15:0] wl);
        logic [31:0] d [16];
        logic [3:0]  s [16];
        logic [9:0]  word;
        logic [9:0]  base;
        logic [9:0]  wa;
        int          span;
        word = a[11:2];
        span = int'(len) + 1;
        base = word - 10'(int'(word) % span);
        for (int i = 0; i <= int'(len); i++) begin
            d[i] = $urandom;
            s[i] = 4'($urandom_range(15));
            case (bt)
                2'b00:   wa = word;
                2'b10:   wa = base + 10'((int'(word - base) + i) % span);
                default: wa = word + 10'(i);
            endcase
            if (!err) exp_wr.push_back({wa, d[i], s[i]});
        end
        exp_b.push_back({id, ((err || !wl[len]) ? 2'b10 : 2'b00)});
        fork
            send_aw(a, len, bt, id);
            for (int i = 0; i <= int'(len) && !abort; i++) send_w(d[i], s[i], wl[i], id);
        join
        bursts_sent++;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_wr.size() != 0 || exp_b.size() != 0) && n < 1000) begin
            @(negedge aclk);
            n++;
        end
        check(tag, 64'(exp_wr.size() + exp_b.size()), 64'(0));
        repeat (3) @(negedge aclk);
        @(posedge aclk); #1;
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_awready"}, 64'(awready), 64'(0));
        check({pfx, "_wready"}, 64'(wready), 64'(0));
        check({pfx, "_bvalid"}, 64'(bvalid), 64'(0));
        check({pfx, "_bram_wen"}, 64'(bram_wen), 64'(0));
        check({pfx, "_start_burst"}, 64'(start_burst), 64'(0));
        check({pfx, "_bid"}, 64'(bid), 64'(0));
        check({pfx, "_bresp"}, 64'(bresp), 64'(0));
        check({pfx, "_bram_waddr"}, 64'(bram_waddr), 64'(0));
    endtask

    initial begin
        int n;
        int base_wr;
        int starts;
        aresetn = 1'b0; awvalid = 1'b0; wvalid = 1'b0; awaddr = '0; awid = '0; awlen = '0;
        awsize = '0; awburst = '0; wdata = '0; wid = '0; wlast = 1'b0; wstb = '0;
        bready = 1'b1; dev_ready = 1'b1; dev_error = 1'b0;

        repeat (3) @(negedge aclk);
        check_reset_outputs("rst");
        @(posedge aclk); #1;
        aresetn = 1'b1;
        @(negedge aclk);
        check("awready_before_edge", 64'(awready), 64'(0));
        @(negedge aclk);
        check("awready_rise", 64'(awready), 64'(1));
        check("wready_rise", 64'(wready), 64'(1));
        @(posedge aclk); #1;

        burst(32'h40, 4'd3, 2'b01, 12'h001, 1'b0, 16'h0008);  wait_idle("incr_done");
        burst(32'h38, 4'd3, 2'b10, 12'h002, 1'b0, 16'h0008);  wait_idle("wrap4_done");
        burst(32'h104, 4'd2, 2'b00, 12'h003, 1'b0, 16'h0004); wait_idle("fixed_done");
        burst(32'hFFC, 4'd1, 2'b01, 12'h004, 1'b0, 16'h0002); wait_idle("incr_top_done");
        burst(32'h200, 4'd2, 2'b11, 12'h007, 1'b0, 16'h0004); wait_idle("reserved_done");
        burst(32'h80, 4'd3, 2'b01, 12'h00A, 1'b0, 16'h000A);  wait_idle("early_wlast_done");
        burst(32'h90, 4'd2, 2'b01, 12'h00B, 1'b0, 16'h0000);  wait_idle("no_wlast_done");
        burst(32'h11C, 4'd7, 2'b10, 12'h00D, 1'b0, 16'h0080); wait_idle("wrap8_done");
        burst(32'h2C, 4'd15, 2'b10, 12'h00E, 1'b0, 16'h8000); wait_idle("wrap16_done");

        dev_error = 1'b1;
        burst(32'h60, 4'd1, 2'b01, 12'h00C, 1'b1, 16'h0002);  wait_idle("deverr_done");
        dev_error = 1'b0;
        burst(32'h64, 4'd0, 2'b01, 12'h00F, 1'b0, 16'h0001);  wait_idle("after_deverr_done");

        dev_ready = 1'b0;
        burst(32'h300, 4'd0, 2'b01, 12'h005, 1'b0, 16'h0001);
        burst(32'h304, 4'd0, 2'b01, 12'h006, 1'b0, 16'h0001);
        wen_log.delete();
        dev_ready = 1'b1;
        wait_idle("b2b_done");
        check("b2b_count", 64'(wen_log.size()), 64'(2));
        if (wen_log.size() == 2) check("b2b_gap", 64'(wen_log[1] - wen_log[0]), 64'(1));

        bready = 1'b0;
        base_wr = wr_seen;
        bursts_sent = 0;
        fork
            begin
                for (int i = 0; i < 6; i++)
                    burst(32'(32'h400 + i * 4), 4'd0, 2'b01, 12'(32 + i), 1'b0, 16'h0001);
            end
        join_none
        n = 0;
        while (bursts_sent < 6 && n < 500) begin @(negedge aclk); n++; end
        check("bfull_sent", 64'(bursts_sent), 64'(6));
        repeat (10) @(negedge aclk);
        check("bfull_writes", 64'(wr_seen - base_wr), 64'(4));
        check("bfull_bvalid", 64'(bvalid), 64'(1));
        starts = 0;
        repeat (10) begin @(negedge aclk); starts += int'(start_burst); end
        check("bfull_nostart", 64'(starts), 64'(0));
        check("bfull_aw_head", 64'(pre_awaddr), 64'(10'h104));
        @(posedge aclk); #1;
        bready = 1'b1;
        wait_idle("bfull_drain");

        base_wr = wr_seen;
        fork
            burst(32'h500, 4'd7, 2'b01, 12'h033, 1'b0, 16'h0080);
        join_none
        n = 0;
        while (wr_seen - base_wr < 2 && n < 200) begin @(negedge aclk); n++; end
        check("rst_mid_reached", 64'(wr_seen - base_wr), 64'(2));
        @(posedge aclk); #1;
        aresetn = 1'b0;
        abort = 1'b1;
        @(negedge aclk);
        check_reset_outputs("rst_mid");
        repeat (4) @(negedge aclk);
        exp_wr.delete();
        exp_b.delete();
        @(posedge aclk); #1;
        abort = 1'b0;
        aresetn = 1'b1;
        repeat (6) @(negedge aclk);
        check("rst_mid_no_b", 64'(bvalid), 64'(0));
        @(posedge aclk); #1;
        burst(32'h11C, 4'd7, 2'b10, 12'h044, 1'b0, 16'h0080); wait_idle("after_reset_done");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got time limit reached, expected bench completion");
        $fatal(1);
    end
endmodule
